time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting controller for a digital clock: seconds prescaler in RUN, three
// edit states with press/auto-repeat increment, edit timeout and field blink.
module time_set_ctrl #(
    parameter int unsigned TICK_DIV    = 32'd50_000_000,
    parameter int unsigned REPEAT_DLY  = 32'd25_000_000,
    parameter int unsigned REPEAT_RATE = 32'd5_000_000,
    parameter int unsigned TIMEOUT     = 32'd500_000_000,
    parameter int unsigned BLINK_DIV   = 32'd12_500_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       modeN,
    input  logic       incN,
    input  logic [5:0] curSec,
    input  logic [5:0] curMin,
    input  logic [4:0] curHour,
    output logic       tickEn,
    output logic       load,
    output logic [5:0] setSec,
    output logic [5:0] setMin,
    output logic [4:0] setHour,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOUR = 2'd1,
        ST_MIN  = 2'd2,
        ST_SEC  = 2'd3
    } state_e;

    localparam logic [31:0] TICK_LAST      = 32'(TICK_DIV - 32'd1);
    localparam logic [31:0] RPT_DLY_LAST   = 32'(REPEAT_DLY - 32'd1);
    localparam logic [31:0] RPT_RATE_LAST  = 32'(REPEAT_RATE - 32'd1);
    localparam logic [31:0] TIMEOUT_LAST   = 32'(TIMEOUT - 32'd1);
    localparam logic [31:0] BLINK_LAST     = 32'(BLINK_DIV - 32'd1);

    state_e      state_q, state_d;
    logic        mode_prev_q, mode_prev_d;
    logic        inc_prev_q, inc_prev_d;
    logic [31:0] pre_q, pre_d;
    logic [31:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_arm_q, rpt_arm_d;
    logic        rpt_first_q, rpt_first_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic        load_q, load_d;
    logic        tick_q, tick_d;
    logic [5:0]  sec_q, sec_d;
    logic [5:0]  min_q, min_d;
    logic [4:0]  hour_q, hour_d;

    logic        mode_press_s;
    logic        inc_press_s;
    logic        in_set_s;
    logic [31:0] rpt_lim_s;
    logic        rpt_fire_s;
    logic        inc_evt_s;
    logic        timeout_s;

    // Button edge detection and event qualification; a mode press always wins.
    always_comb begin
        mode_press_s = mode_prev_q & ~modeN;
        inc_press_s  = inc_prev_q & ~incN;
        in_set_s     = (state_q != ST_RUN);
        rpt_lim_s    = rpt_first_q ? RPT_DLY_LAST : RPT_RATE_LAST;
        rpt_fire_s   = in_set_s & rpt_arm_q & ~incN & ~inc_press_s & ~mode_press_s
                       & (rpt_cnt_q == rpt_lim_s);
        inc_evt_s    = in_set_s & ~mode_press_s & (inc_press_s | rpt_fire_s);
        timeout_s    = in_set_s & ~mode_press_s & ~inc_evt_s & (idle_cnt_q == TIMEOUT_LAST);
    end

    // Mode FSM next state; load pulses only when leaving SET_SEC by a press.
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_press_s) begin
                    state_d = ST_HOUR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOUR: begin
                if (mode_press_s) begin
                    state_d = ST_MIN;
                end else if (timeout_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOUR;
                end
            end
            ST_MIN: begin
                if (mode_press_s) begin
                    state_d = ST_SEC;
                end else if (timeout_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_MIN;
                end
            end
            ST_SEC: begin
                if (mode_press_s) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (timeout_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SEC;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Edit registers: snapshot live time on session entry, then per-field increments.
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if ((state_q == ST_RUN) && mode_press_s) begin
            sec_d  = curSec;
            min_d  = curMin;
            hour_d = curHour;
        end else if (inc_evt_s) begin
            case (state_q)
                ST_HOUR: hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                ST_MIN:  min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                ST_SEC:  sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                default: sec_d  = sec_q;
            endcase
        end else begin
            sec_d = sec_q;
        end
    end

    // Auto-repeat timer: armed by a fresh press, cleared by release or any state change.
    always_comb begin
        rpt_arm_d   = rpt_arm_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        if ((state_d != state_q) || mode_press_s) begin
            rpt_arm_d   = 1'b0;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = 32'd0;
        end else if (in_set_s && inc_press_s) begin
            rpt_arm_d   = 1'b1;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = 32'd0;
        end else if (rpt_fire_s) begin
            rpt_first_d = 1'b0;
            rpt_cnt_d   = 32'd0;
        end else if (rpt_arm_q && !incN) begin
            rpt_cnt_d = rpt_cnt_q + 32'd1;
        end else begin
            rpt_arm_d   = 1'b0;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = 32'd0;
        end
    end

    // Prescaler holds through the load cycle so the first tick lands TICK_DIV cycles after load.
    always_comb begin
        pre_d = pre_q;
        if (state_d != ST_RUN) begin
            pre_d = 32'd0;
        end else if ((state_q != ST_RUN) || load_q) begin
            pre_d = 32'd0;
        end else if (pre_q == TICK_LAST) begin
            pre_d = 32'd0;
        end else begin
            pre_d = pre_q + 32'd1;
        end
        tick_d = (state_d == ST_RUN) && (pre_d == TICK_LAST);
    end

    // Idle timeout counter and blink generator, both restarted on every field entry.
    always_comb begin
        idle_cnt_d  = idle_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (state_d == ST_RUN) begin
            idle_cnt_d = 32'd0;
        end else if ((state_d != state_q) || inc_evt_s) begin
            idle_cnt_d = 32'd0;
        end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end
        if (state_d == ST_RUN) begin
            blink_d     = 1'b0;
            blink_cnt_d = 32'd0;
        end else if (state_d != state_q) begin
            blink_d     = 1'b1;
            blink_cnt_d = 32'd0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = 32'd0;
        end else begin
            blink_cnt_d = blink_cnt_q + 32'd1;
        end
        mode_prev_d = modeN;
        inc_prev_d  = incN;
    end

    // State register; button history resets to "pressed" so a held button never fires on release of reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_RUN;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            pre_q       <= 32'd0;
            rpt_cnt_q   <= 32'd0;
            rpt_arm_q   <= 1'b0;
            rpt_first_q <= 1'b1;
            idle_cnt_q  <= 32'd0;
            blink_cnt_q <= 32'd0;
            blink_q     <= 1'b0;
            load_q      <= 1'b0;
            tick_q      <= 1'b0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 5'd0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
            pre_q       <= pre_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_arm_q   <= rpt_arm_d;
            rpt_first_q <= rpt_first_d;
            idle_cnt_q  <= idle_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            load_q      <= load_d;
            tick_q      <= tick_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
        end
    end

    assign tickEn  = tick_q;
    assign load    = load_q;
    assign setSec  = sec_q;
    assign setMin  = min_q;
    assign setHour = hour_q;
    assign mode    = state_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: vector table for the edit flow plus
// hand-written sequences for repeat, load/tick timing, timeout and reset.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       modeN;
    logic       incN;
    logic [5:0] curSec;
    logic [5:0] curMin;
    logic [4:0] curHour;
    logic       tickEn;
    logic       load;
    logic [5:0] setSec;
    logic [5:0] setMin;
    logic [4:0] setHour;
    logic [1:0] mode;
    logic       blink;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  mode_n;
        logic  inc_n;
        int    mode;
        int    hour;
        int    min;
        int    sec;
        string name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    time_set_ctrl #(
        .TICK_DIV   (32'd4),
        .REPEAT_DLY (32'd6),
        .REPEAT_RATE(32'd2),
        .TIMEOUT    (32'd40),
        .BLINK_DIV  (32'd3)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .modeN  (modeN),
        .incN   (incN),
        .curSec (curSec),
        .curMin (curMin),
        .curHour(curHour),
        .tickEn (tickEn),
        .load   (load),
        .setSec (setSec),
        .setMin (setMin),
        .setHour(setHour),
        .mode   (mode),
        .blink  (blink)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic mn, input logic inn, input int m, input int h,
                                    input int mi, input int s, input string nm);
        vec_t v;
        v.mode_n = mn;
        v.inc_n  = inn;
        v.mode   = m;
        v.hour   = h;
        v.min    = mi;
        v.sec    = s;
        v.name   = nm;
        vecs.push_back(v);
    endfunction

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int hold_exp[12];

        add_vec(1'b0, 1'b1, 1, 12, 34, 56, "enter_hour");
        add_vec(1'b1, 1'b1, 1, 12, 34, 56, "rel_mode");
        for (int i = 1; i <= 12; i++) begin
            add_vec(1'b1, 1'b0, 1, (12 + i) % 24, 34, 56, "hour_inc");
            add_vec(1'b1, 1'b1, 1, (12 + i) % 24, 34, 56, "hour_rel");
        end
        add_vec(1'b0, 1'b1, 2, 0, 34, 56, "to_min");
        add_vec(1'b1, 1'b1, 2, 0, 34, 56, "rel_mode2");
        for (int i = 1; i <= 24; i++) begin
            add_vec(1'b1, 1'b0, 2, 0, 34 + i, 56, "min_inc");
            add_vec(1'b1, 1'b1, 2, 0, 34 + i, 56, "min_rel");
        end
        hold_exp = '{59, 59, 59, 59, 59, 59, 0, 0, 1, 1, 2, 2};

        resetN  = 1'b0;
        modeN   = 1'b1;
        incN    = 1'b1;
        curSec  = 6'd56;
        curMin  = 6'd34;
        curHour = 5'd12;
        repeat (3) @(negedge clk);
        chk("rst_mode", mode, 0);
        chk("rst_tick", tickEn, 0);
        chk("rst_load", load, 0);
        chk("rst_blink", blink, 0);
        chk("rst_set", {setHour, setMin, setSec}, 0);
        resetN = 1'b1;

        // Free run: cycle i is the one ending at the i-th edge after release.
        for (int i = 1; i <= 20; i++) begin
            chk("free_tick", tickEn, (i % 4 == 0) ? 1 : 0);
            chk("free_mode", mode, 0);
            chk("free_load", load, 0);
            @(negedge clk);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            modeN = vecs[i].mode_n;
            incN  = vecs[i].inc_n;
            @(negedge clk);
            chk({vecs[i].name, "_mode"}, mode, vecs[i].mode);
            chk({vecs[i].name, "_hour"}, setHour, vecs[i].hour);
            chk({vecs[i].name, "_min"}, setMin, vecs[i].min);
            chk({vecs[i].name, "_sec"}, setSec, vecs[i].sec);
            chk({vecs[i].name, "_load"}, load, 0);
        end

        // Held incN in SET_MIN from 58: press, then repeat after 6, then every 2.
        incN = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("hold_min", setMin, hold_exp[k]);
            chk("hold_mode", mode, 2);
            if (k == 10) incN = 1'b1;
        end

        modeN = 1'b0;
        @(negedge clk);
        chk("to_sec_mode", mode, 3);
        chk("to_sec_blink", blink, 1);
        modeN = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            incN = 1'b0;
            @(negedge clk);
            chk("sec_inc", setSec, (56 + i) % 60);
            incN = 1'b1;
            @(negedge clk);
        end

        modeN = 1'b0;
        @(negedge clk);
        chk("exit_mode", mode, 0);
        chk("exit_load", load, 1);
        chk("exit_tick", tickEn, 0);
        chk("exit_set", {setHour, setMin, setSec}, {5'd0, 6'd2, 6'd0});
        modeN = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk("post_load", load, 0);
            chk("post_tick", tickEn, (j == 4) ? 1 : 0);
        end

        // Abandoned session: no input for TIMEOUT cycles after entry.
        modeN = 1'b0;
        @(negedge clk);
        chk("to_entry_mode", mode, 1);
        chk("to_entry_blink", blink, 1);
        chk("to_entry_hour", setHour, 12);
        modeN = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            chk("to_load", load, 0);
            if (k <= 7) chk("to_blink", blink, ((k / 3) % 2 == 0) ? 1 : 0);
            if (k == 39) chk("to_before", mode, 1);
            if (k >= 40) begin
                chk("to_after", mode, 0);
                chk("to_blink_run", blink, 0);
            end
        end

        // Simultaneous mode and inc press: mode wins, held inc does not repeat.
        modeN = 1'b0;
        @(negedge clk);
        chk("sim_entry", mode, 1);
        modeN = 1'b1;
        @(negedge clk);
        modeN = 1'b0;
        incN  = 1'b0;
        @(negedge clk);
        chk("sim_mode", mode, 2);
        chk("sim_hour", setHour, 12);
        chk("sim_min", setMin, 34);
        modeN = 1'b1;
        repeat (10) @(negedge clk);
        chk("sim_norepeat_min", setMin, 34);
        chk("sim_norepeat_mode", mode, 2);

        // Reset mid-session with incN still held.
        resetN = 1'b0;
        #1;
        chk("mrst_mode", mode, 0);
        chk("mrst_set", {setHour, setMin, setSec}, 0);
        chk("mrst_blink", blink, 0);
        chk("mrst_load", load, 0);
        chk("mrst_tick", tickEn, 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_rel_mode", mode, 0);
        chk("mrst_rel_load", load, 0);
        chk("mrst_rel_min", setMin, 0);
        modeN = 1'b0;
        @(negedge clk);
        chk("mrst_entry_hour", setHour, 12);
        modeN = 1'b1;
        repeat (8) @(negedge clk);
        chk("mrst_held_hour", setHour, 12);
        chk("mrst_held_mode", mode, 1);
        incN = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
